// File: rtl/key_pkg.sv
// Shared types and helpers for the multi-channel key debouncer.
// Holds the per-channel FSM state encoding and the counter-width function.
package key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_FILT = 2'd1,
        ST_HELD       = 2'd2,
        ST_REL_FILT   = 2'd3
    } key_state_e;

    // Bits needed to hold values 0..max_count (never less than one bit).
    function automatic int cnt_width(input int max_count);
        int w;
        if (max_count < 2) begin
            w = 1;
        end else begin
            w = $clog2(max_count + 1);
        end
        return w;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchronizer, debounce FSM, filter and hold counters.
// All pulse and level outputs come straight from flops.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int T20MS     = 1_000_000,
    parameter int T_LONG    = 50_000_000,
    parameter int T_REP     = 10_000_000,
    parameter int REPEAT_EN = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic keyin_n,
    output logic key_down,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic key_rep
);

    localparam int FW = cnt_width(T20MS);
    localparam int HW = cnt_width(T_LONG + T_REP);
    // The sample that leaves IDLE is the first of the T20MS filter samples.
    localparam logic [FW-1:0] FILT_LAST = FW'(T20MS - 2);
    localparam logic [HW-1:0] HOLD_LONG = HW'(T_LONG);
    localparam logic [HW-1:0] HOLD_WRAP = HW'(T_LONG + T_REP);

    logic            r_sync0;
    logic            r_sync1;
    key_state_e      r_state;
    key_state_e      w_state_nxt;
    logic [FW-1:0]   r_filt;
    logic [FW-1:0]   w_filt_nxt;
    logic [HW-1:0]   r_hold;
    logic [HW-1:0]   w_hold_nxt;
    logic [HW-1:0]   w_hold_inc;
    logic            w_low;
    logic            r_down;
    logic            r_press;
    logic            r_release;
    logic            r_long;
    logic            r_rep;
    logic            w_down_nxt;
    logic            w_press_nxt;
    logic            w_release_nxt;
    logic            w_long_nxt;
    logic            w_rep_nxt;

    assign w_low      = ~r_sync1;
    assign w_hold_inc = r_hold + HW'(1);

    // Two-flop synchronizer, reset to the released (high) level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync0 <= 1'b1;
            r_sync1 <= 1'b1;
        end else begin
            r_sync0 <= keyin_n;
            r_sync1 <= r_sync0;
        end
    end

    // Next-state, counter and pulse decode for the debounce FSM.
    always_comb begin
        w_state_nxt   = r_state;
        w_filt_nxt    = r_filt;
        w_hold_nxt    = r_hold;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_long_nxt    = 1'b0;
        w_rep_nxt     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_low) begin
                    w_state_nxt = ST_PRESS_FILT;
                    w_filt_nxt  = {FW{1'b0}};
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PRESS_FILT: begin
                if (!w_low) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_filt == FILT_LAST) begin
                    w_state_nxt = ST_HELD;
                    w_press_nxt = 1'b1;
                    w_hold_nxt  = {HW{1'b0}};
                end else begin
                    w_filt_nxt  = r_filt + FW'(1);
                end
            end
            ST_HELD: begin
                if (!w_low) begin
                    w_state_nxt = ST_REL_FILT;
                    w_filt_nxt  = {FW{1'b0}};
                end else begin
                    // Wrap back to T_LONG each repeat period so the count never re-hits T_LONG.
                    if (w_hold_inc == HOLD_WRAP) begin
                        w_hold_nxt = HOLD_LONG;
                        w_rep_nxt  = (REPEAT_EN != 0);
                    end else begin
                        w_hold_nxt = w_hold_inc;
                    end
                    if (w_hold_inc == HOLD_LONG) begin
                        w_long_nxt = 1'b1;
                    end else begin
                        w_long_nxt = 1'b0;
                    end
                end
            end
            ST_REL_FILT: begin
                if (w_low) begin
                    w_state_nxt = ST_HELD;
                end else if (r_filt == FILT_LAST) begin
                    w_state_nxt   = ST_IDLE;
                    w_release_nxt = 1'b1;
                end else begin
                    w_filt_nxt    = r_filt + FW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_down_nxt = (w_state_nxt == ST_HELD) || (w_state_nxt == ST_REL_FILT);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_filt    <= {FW{1'b0}};
            r_hold    <= {HW{1'b0}};
            r_down    <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_rep     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_filt    <= w_filt_nxt;
            r_hold    <= w_hold_nxt;
            r_down    <= w_down_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_long    <= w_long_nxt;
            r_rep     <= w_rep_nxt;
        end
    end

    assign key_down    = r_down;
    assign key_press   = r_press;
    assign key_release = r_release;
    assign key_long    = r_long;
    assign key_rep     = r_rep;

endmodule

// File: rtl/key_debounce_multi.sv
// Multi-key debouncer: N_KEYS fully independent channels with press,
// release, long-press and auto-repeat pulses.
module key_debounce_multi #(
    parameter int N_KEYS    = 4,
    parameter int T20MS     = 1_000_000,
    parameter int T_LONG    = 50_000_000,
    parameter int T_REP     = 10_000_000,
    parameter int REPEAT_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] keyin_n,
    output logic [N_KEYS-1:0] key_down,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long,
    output logic [N_KEYS-1:0] key_rep
);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .T20MS     (T20MS),
            .T_LONG    (T_LONG),
            .T_REP     (T_REP),
            .REPEAT_EN (REPEAT_EN)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .keyin_n     (keyin_n[g]),
            .key_down    (key_down[g]),
            .key_press   (key_press[g]),
            .key_release (key_release[g]),
            .key_long    (key_long[g]),
            .key_rep     (key_rep[g])
        );
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Self-checking bench for key_debounce_multi: directed scenarios plus random
// key activity, compared every cycle against a run-length reference model.
module tb_key_debounce_multi;

    localparam int N  = 4;
    localparam int TF = 20;
    localparam int TL = 100;
    localparam int TR = 30;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] keyin_n;
    logic [N-1:0] a_down, a_press, a_rel, a_long, a_rep;
    logic [N-1:0] b_down, b_press, b_rel, b_long, b_rep;

    always #10 clk = ~clk;

    key_debounce_multi #(.N_KEYS(N), .T20MS(TF), .T_LONG(TL), .T_REP(TR), .REPEAT_EN(1)) u_dut (
        .clk(clk), .rst(rst), .keyin_n(keyin_n), .key_down(a_down), .key_press(a_press),
        .key_release(a_rel), .key_long(a_long), .key_rep(a_rep)
    );

    key_debounce_multi #(.N_KEYS(N), .T20MS(TF), .T_LONG(TL), .T_REP(TR), .REPEAT_EN(0)) u_dut_norep (
        .clk(clk), .rst(rst), .keyin_n(keyin_n), .key_down(b_down), .key_press(b_press),
        .key_release(b_rel), .key_long(b_long), .key_rep(b_rep)
    );

    // Reference model: debounced level flips after TF equal samples; hold time
    // counts consecutive low samples after the press, long at TL, repeat every TR after.
    logic [N-1:0] m_s0 = '1, m_s1 = '1, m_down = '0, m_prev_low = '0;
    logic [N-1:0] m_press = '0, m_rel = '0, m_long = '0, m_rep = '0;
    int m_run_low[N], m_run_high[N], m_hold[N];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_any = 0;
    int n_rep_b0 = 0;
    int q_press0[$], q_rel0[$], q_long0[$], q_rep0[$];

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_lat(input string tag, input int lat);
        n_cmp++;
        assert (lat >= 21 && lat <= 23) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0d expected=22+-1", tag, cyc, lat);
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] smp;
        logic         low;
        if (rst) begin
            m_s0 = '1; m_s1 = '1; m_down = '0; m_prev_low = '0;
            m_press = '0; m_rel = '0; m_long = '0; m_rep = '0;
            for (int i = 0; i < N; i++) begin
                m_run_low[i] = 0; m_run_high[i] = 0; m_hold[i] = 0;
            end
        end else begin
            smp  = m_s1;
            m_s1 = m_s0;
            m_s0 = keyin_n;
            m_press = '0; m_rel = '0; m_long = '0; m_rep = '0;
            for (int i = 0; i < N; i++) begin
                low = ~smp[i];
                if (!m_down[i]) begin
                    m_run_low[i] = low ? m_run_low[i] + 1 : 0;
                    if (m_run_low[i] == TF) begin
                        m_down[i] = 1'b1; m_press[i] = 1'b1;
                        m_hold[i] = 0; m_run_low[i] = 0; m_run_high[i] = 0;
                    end
                end else if (!low) begin
                    m_run_high[i]++;
                    if (m_run_high[i] == TF) begin
                        m_down[i] = 1'b0; m_rel[i] = 1'b1;
                        m_run_high[i] = 0; m_run_low[i] = 0;
                    end
                end else begin
                    m_run_high[i] = 0;
                    if (m_prev_low[i]) begin
                        m_hold[i]++;
                        if (m_hold[i] == TL) m_long[i] = 1'b1;
                        if (m_hold[i] > TL && ((m_hold[i] - TL) % TR) == 0) m_rep[i] = 1'b1;
                    end
                end
                m_prev_low[i] = low;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        chk("down",      a_down,  m_down);
        chk("press",     a_press, m_press);
        chk("release",   a_rel,   m_rel);
        chk("long",      a_long,  m_long);
        chk("rep",       a_rep,   m_rep);
        chk("nr_down",   b_down,  m_down);
        chk("nr_press",  b_press, m_press);
        chk("nr_release",b_rel,   m_rel);
        chk("nr_long",   b_long,  m_long);
        chk("nr_rep",    b_rep,   '0);
        if (|{a_press, a_rel, a_long, a_rep}) n_any++;
        if (b_rep[0]) n_rep_b0++;
        if (a_press[0]) q_press0.push_back(cyc);
        if (a_rel[0])   q_rel0.push_back(cyc);
        if (a_long[0])  q_long0.push_back(cyc);
        if (a_rep[0])   q_rep0.push_back(cyc);
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int   t0, p0, n_long_before, n_rep_before, dur;
        logic seen;

        // Reset with all keys released, then a quiet period.
        rst = 1'b1; keyin_n = '1;
        steps(10);
        chk("reset_outputs", a_down | a_press | a_rel | a_long | a_rep, '0);
        rst = 1'b0;
        n_any = 0;
        steps(100);
        chk_int("quiet_pulses", n_any, 0);

        // Bouncy press on ch0, then steady low.
        for (int b = 0; b < 3; b++) begin
            keyin_n[0] = 1'b0; steps(2);
            keyin_n[0] = 1'b1; steps(2);
        end
        keyin_n[0] = 1'b0; t0 = cyc;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin step(); seen = a_press[0]; end
        chk_int("press0_seen", int'(seen), 1);
        chk_lat("press0_latency", cyc - t0);
        chk("press0_down", a_down, 4'b0001);
        chk_int("press0_count", q_press0.size(), 1);
        p0 = cyc;

        // Hold 260 cycles: one long at +100, repeats at +130..+250.
        steps(260);
        chk_int("long0_count", q_long0.size(), 1);
        if (q_long0.size() > 0) chk_int("long0_time", q_long0[0] - p0, TL);
        chk_int("rep0_count", q_rep0.size(), 5);
        if (q_rep0.size() == 5) begin
            chk_int("rep0_first", q_rep0[0] - p0, TL + TR);
            chk_int("rep0_last",  q_rep0[4] - p0, TL + 5 * TR);
        end
        chk_int("norep_count", n_rep_b0, 0);

        // Bouncy release on ch0.
        n_long_before = q_long0.size(); n_rep_before = q_rep0.size();
        for (int b = 0; b < 3; b++) begin
            keyin_n[0] = 1'b1; steps(2);
            keyin_n[0] = 1'b0; steps(2);
        end
        keyin_n[0] = 1'b1; t0 = cyc;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin step(); seen = a_rel[0]; end
        chk_int("rel0_seen", int'(seen), 1);
        chk_lat("rel0_latency", cyc - t0);
        chk_int("rel0_count", q_rel0.size(), 1);
        chk_int("rel0_no_extra_press", q_press0.size(), 1);
        chk_int("rel0_no_long", q_long0.size(), n_long_before);
        chk_int("rel0_no_rep", q_rep0.size(), n_rep_before);

        // Ch2 held, then ch1 press and ch2 release land on the same cycle.
        keyin_n[2] = 1'b0; steps(40);
        keyin_n[1] = 1'b0; keyin_n[2] = 1'b1; t0 = cyc;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin step(); seen = a_press[1]; end
        chk_int("press1_seen", int'(seen), 1);
        chk_lat("press1_latency", cyc - t0);
        chk("sim_press", a_press, 4'b0010);
        chk("sim_release", a_rel, 4'b0100);
        keyin_n[1] = 1'b1; steps(40);

        // Reset while ch0 is held; no release, then a fresh full-filter press.
        keyin_n[0] = 1'b0; steps(40);
        q_rel0.delete(); q_press0.delete();
        rst = 1'b1; step();
        chk("rst_held_outputs", a_down | a_press | a_rel | a_long | a_rep, '0);
        rst = 1'b0; t0 = cyc;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin step(); seen = a_press[0]; end
        chk_int("rst_press_seen", int'(seen), 1);
        chk_lat("rst_press_latency", cyc - t0);
        chk_int("rst_no_release", q_rel0.size(), 0);

        // Random activity on all channels with occasional resets.
        for (int it = 0; it < 150; it++) begin
            keyin_n = N'($urandom);
            rst = ($urandom_range(0, 39) == 0);
            dur = ($urandom_range(0, 7) == 0) ? int'($urandom_range(100, 160)) : int'($urandom_range(1, 25));
            steps(dur);
        end
        rst = 1'b0; keyin_n = '1;
        steps(60);
        chk("final_idle", a_down, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
